// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Radix-2 restoring divider, one quotient bit per clock, with
//               RISC-V DIV/DIVU/REM/REMU results over valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_sign = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [WIDTH-1:0] c_min       = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvsr;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_dz;
    logic             w_ovf;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

    assign w_accept = in_valid && in_ready && !flush;
    assign w_dz     = (divisor == '0);
    assign w_ovf    = is_signed && (dividend == c_min) && (divisor == '1);
    assign w_a_neg  = is_signed && dividend[WIDTH-1];
    assign w_b_neg  = is_signed && divisor[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -dividend : dividend;
    assign w_b_mag  = w_b_neg ? -divisor  : divisor;

    // Borrow out of the WIDTH+1 bit subtraction doubles as the compare result.
    assign w_rem_sh = {r_rem, r_q[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvsr};
    assign w_ge     = ~w_diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        w_state_nxt = (w_dz || w_ovf) ? c_st_done : c_st_calc;
                    end
                end
                c_st_calc: begin
                    if (r_cnt == c_last_iter) begin
                        w_state_nxt = c_st_sign;
                    end
                end
                c_st_sign: w_state_nxt = c_st_done;
                c_st_done: begin
                    if (out_ready) begin
                        w_state_nxt = c_st_idle;
                    end
                end
                default:   w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_dvsr      <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else if (!flush) begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        if (w_dz) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_div_zero  <= 1'b1;
                        end else if (w_ovf) begin
                            r_quotient  <= c_min;
                            r_remainder <= '0;
                            r_div_zero  <= 1'b0;
                        end else begin
                            r_q     <= w_a_mag;
                            r_dvsr  <= w_b_mag;
                            r_rem   <= '0;
                            r_cnt   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                c_st_calc: begin
                    r_q   <= {r_q[WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                c_st_sign: begin
                    r_quotient  <= r_neg_q ? -r_q : r_q;
                    r_remainder <= r_neg_r ? -r_rem : r_rem;
                    r_div_zero  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
